// File: rtl/buf_fill_ctrl.sv
// Ping-pong frame buffer fill controller: host valid/ready in, buffer write port out.
// Fills Buf0/Buf1 alternately with AIPOut_PD*AILOut_PD words and tracks full/release.
// Ports:
//   clk, reset          : clock, async active-low reset
//   AIPOut_PD/AILOut_PD : frame geometry, sampled only between fills
//   HostValid/HostData/HostSOF/HostReady : host word handshake
//   WData/WAddr/WE0/WE1 : shared buffer write port, one strobe per buffer
//   Buf0Full/Buf1Full   : buffer holds a complete frame
//   Buf0Release/Buf1Release : controller finished reading a buffer
//   SofErr              : sticky frame-sync error
module buf_fill_ctrl #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        AIPOut_PD,
    input  logic [9:0]        AILOut_PD,
    input  logic              HostValid,
    input  logic [DATA_W-1:0] HostData,
    input  logic              HostSOF,
    output logic              HostReady,
    output logic [DATA_W-1:0] WData,
    output logic [ADDR_W-1:0] WAddr,
    output logic              WE0,
    output logic              WE1,
    output logic              Buf0Full,
    output logic              Buf1Full,
    input  logic              Buf0Release,
    input  logic              Buf1Release,
    output logic              SofErr
);

    typedef enum logic [1:0] {
        IDLE,
        FILL0,
        FILL1,
        WAIT
    } state_t;

    state_t            state, state_n;
    logic              target, target_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [ADDR_W-1:0] size, size_n;
    logic              sof_err_n;
    logic              full0_set, full1_set;
    logic              full0_n, full1_n;
    logic              ready_n;

    logic [19:0]       prod;
    logic              xfer;
    logic              resync;
    logic [ADDR_W-1:0] eff_addr;
    logic              last;

    assign prod     = 20'(AIPOut_PD) * 20'(AILOut_PD);
    assign xfer     = HostValid & HostReady;
    // SOF mid-frame restarts the fill at address 0 of the same buffer
    assign resync   = HostSOF & (cnt != '0);
    assign eff_addr = resync ? '0 : cnt;
    assign last     = (eff_addr == size - ADDR_W'(1));

    always_comb begin
        state_n   = state;
        target_n  = target;
        cnt_n     = cnt;
        size_n    = size;
        sof_err_n = SofErr;
        full0_set = 1'b0;
        full1_set = 1'b0;
        unique case (state)
            IDLE: begin
                size_n = ADDR_W'(prod);
                if (prod != '0) begin
                    if (target)
                        state_n = Buf1Full ? WAIT : FILL1;
                    else
                        state_n = Buf0Full ? WAIT : FILL0;
                end
            end
            FILL0, FILL1: begin
                if (xfer) begin
                    if (resync || (!HostSOF && cnt == '0))
                        sof_err_n = 1'b1;
                    if (last) begin
                        cnt_n    = '0;
                        target_n = ~target;
                        state_n  = IDLE;
                        full0_set = ~target;
                        full1_set = target;
                    end else begin
                        cnt_n = eff_addr + ADDR_W'(1);
                    end
                end
            end
            WAIT: begin
                if (!(target ? Buf1Full : Buf0Full))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Set and release never target the same buffer in one cycle
    assign full0_n = full0_set | (Buf0Full & ~Buf0Release);
    assign full1_n = full1_set | (Buf1Full & ~Buf1Release);

    // Ready is registered from the next state, so it drops right after the last word
    assign ready_n = ((state_n == FILL0) && !full0_n) ||
                     ((state_n == FILL1) && !full1_n);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            target    <= 1'b0;
            cnt       <= '0;
            size      <= '0;
            HostReady <= 1'b0;
            WData     <= '0;
            WAddr     <= '0;
            WE0       <= 1'b0;
            WE1       <= 1'b0;
            Buf0Full  <= 1'b0;
            Buf1Full  <= 1'b0;
            SofErr    <= 1'b0;
        end else begin
            state     <= state_n;
            target    <= target_n;
            cnt       <= cnt_n;
            size      <= size_n;
            HostReady <= ready_n;
            Buf0Full  <= full0_n;
            Buf1Full  <= full1_n;
            SofErr    <= sof_err_n;
            WE0       <= xfer & ~target;
            WE1       <= xfer & target;
            if (xfer) begin
                WData <= HostData;
                WAddr <= eff_addr;
            end
        end
    end

endmodule

// File: tb/tb_buf_fill_ctrl.sv
// Directed bench for buf_fill_ctrl: ping-pong fill, release, gaps, resync,
// zero size and mid-fill reset, with hand-computed write logs.
module tb_buf_fill_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  AIPOut_PD = '0;
    logic [9:0]  AILOut_PD = '0;
    logic        HostValid = 1'b0;
    logic [31:0] HostData = '0;
    logic        HostSOF = 1'b0;
    logic        HostReady;
    logic [31:0] WData;
    logic [19:0] WAddr;
    logic        WE0, WE1;
    logic        Buf0Full, Buf1Full;
    logic        Buf0Release = 1'b0;
    logic        Buf1Release = 1'b0;
    logic        SofErr;

    buf_fill_ctrl dut (
        .clk(clk), .reset(reset),
        .AIPOut_PD(AIPOut_PD), .AILOut_PD(AILOut_PD),
        .HostValid(HostValid), .HostData(HostData), .HostSOF(HostSOF),
        .HostReady(HostReady),
        .WData(WData), .WAddr(WAddr), .WE0(WE0), .WE1(WE1),
        .Buf0Full(Buf0Full), .Buf1Full(Buf1Full),
        .Buf0Release(Buf0Release), .Buf1Release(Buf1Release),
        .SofErr(SofErr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int both_we = 0;

    logic        wb[$];
    logic [19:0] wa[$];
    logic [31:0] wd[$];
    logic        wf[$];
    int          wc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (WE0 || WE1) begin
            wb.push_back(WE1);
            wa.push_back(WAddr);
            wd.push_back(WData);
            wf.push_back(WE1 ? Buf1Full : Buf0Full);
            wc.push_back(cyc);
        end
        if (WE0 && WE1) both_we++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        wb.delete(); wa.delete(); wd.delete(); wf.delete(); wc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        HostValid = 1'b0;
        HostSOF = 1'b0;
        step();
        reset = 1'b1;
        clr_log();
    endtask

    task automatic wait_ready();
        int b = 0;
        while (!HostReady && b < 60) begin
            step();
            b++;
        end
        if (!HostReady) chk("ready_timeout", 0, 1);
    endtask

    task automatic feed(input int n, input int sof_at, input bit gap,
                        input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            HostValid = 1'b1;
            HostData = base + 32'(i);
            HostSOF = (i == sof_at);
            wait_ready();
            step();
            if (gap) begin
                HostValid = 1'b0;
                HostSOF = 1'b0;
                step();
            end
        end
        HostValid = 1'b0;
        HostSOF = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic b,
                          input logic [19:0] a, input logic [31:0] d,
                          input logic f);
        if (idx >= wb.size()) begin
            chk({tag, "_missing"}, 64'(wb.size()), 64'(idx + 1));
        end else begin
            chk(tag, {wb[idx], wa[idx], wd[idx], wf[idx]}, {b, a, d, f});
        end
    endtask

    initial begin
        int bad;
        #1;
        chk("reset_outs",
            {HostReady, WE0, WE1, Buf0Full, Buf1Full, SofErr, WData, WAddr}, 0);

        // ping-pong fill of both buffers, held valid
        AIPOut_PD = 10'd4;
        AILOut_PD = 10'd2;
        step();
        reset = 1'b1;
        clr_log();
        feed(8, 0, 1'b0, 32'h100);
        feed(8, 0, 1'b0, 32'h200);
        repeat (3) step();
        chk("t1_nwr", 64'(wb.size()), 16);
        for (int i = 0; i < 8; i++)
            chk_wr("t1_b0", i, 1'b0, 20'(i), 32'h100 + 32'(i), i == 7);
        for (int i = 0; i < 8; i++)
            chk_wr("t1_b1", 8 + i, 1'b1, 20'(i), 32'h200 + 32'(i), i == 7);
        chk("t1_full", {Buf0Full, Buf1Full}, 2'b11);
        chk("t1_wait_rdy", HostReady, 0);
        chk("t1_soferr", SofErr, 0);

        // release buffer 0 and refill it
        clr_log();
        Buf0Release = 1'b1;
        step();
        Buf0Release = 1'b0;
        chk("t2_rel", {Buf0Full, Buf1Full}, 2'b01);
        step();
        step();
        chk("t2_ready", HostReady, 1);
        feed(8, 0, 1'b0, 32'h300);
        step();
        chk_wr("t2_first", 0, 1'b0, 20'd0, 32'h300, 1'b0);
        chk_wr("t2_last", 7, 1'b0, 20'd7, 32'h307, 1'b1);
        Buf0Release = 1'b1;
        Buf1Release = 1'b1;
        step();
        Buf0Release = 1'b0;
        Buf1Release = 1'b0;
        chk("t2_relboth", {Buf0Full, Buf1Full}, 2'b00);

        // toggled valid, 3-word frame
        do_reset();
        AIPOut_PD = 10'd3;
        AILOut_PD = 10'd1;
        feed(3, 0, 1'b1, 32'h400);
        step();
        chk("t3_nwr", 64'(wb.size()), 3);
        for (int i = 0; i < 3; i++)
            chk_wr("t3_wr", i, 1'b0, 20'(i), 32'h400 + 32'(i), i == 2);
        if (wc.size() == 3) begin
            chk("t3_gap1", 64'(wc[1] - wc[0]), 2);
            chk("t3_gap2", 64'(wc[2] - wc[1]), 2);
        end else begin
            chk("t3_gapcnt", 64'(wc.size()), 3);
        end

        // SOF on 5th word of an 8-word fill
        do_reset();
        AIPOut_PD = 10'd4;
        AILOut_PD = 10'd2;
        feed(4, 0, 1'b0, 32'h500);
        feed(8, 0, 1'b0, 32'h600);
        step();
        chk("t4_nwr", 64'(wb.size()), 12);
        chk_wr("t4_w3", 3, 1'b0, 20'd3, 32'h503, 1'b0);
        chk_wr("t4_sof", 4, 1'b0, 20'd0, 32'h600, 1'b0);
        chk_wr("t4_w10", 10, 1'b0, 20'd6, 32'h606, 1'b0);
        chk_wr("t4_last", 11, 1'b0, 20'd7, 32'h607, 1'b1);
        chk("t4_soferr", SofErr, 1);

        // zero size, then non-SOF start and mid-fill geometry change
        do_reset();
        AIPOut_PD = 10'd0;
        AILOut_PD = 10'd1;
        bad = 0;
        repeat (20) begin
            step();
            if (HostReady) bad++;
        end
        chk("t5_sz0", 64'(bad), 0);
        AIPOut_PD = 10'd2;
        feed(1, -1, 1'b0, 32'h700);
        AIPOut_PD = 10'd5;
        feed(1, -1, 1'b0, 32'h701);
        step();
        chk("t5_nwr", 64'(wb.size()), 2);
        chk_wr("t5_w0", 0, 1'b0, 20'd0, 32'h700, 1'b0);
        chk_wr("t5_w1", 1, 1'b0, 20'd1, 32'h701, 1'b1);
        chk("t5_soferr", SofErr, 1);

        // reset mid-fill
        do_reset();
        AIPOut_PD = 10'd4;
        AILOut_PD = 10'd2;
        feed(3, 0, 1'b0, 32'h800);
        chk("t6_pre_we", WE0, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_outs",
            {HostReady, WE0, WE1, Buf0Full, Buf1Full, SofErr, WData, WAddr}, 0);
        step();
        reset = 1'b1;
        clr_log();
        feed(1, 0, 1'b0, 32'h900);
        step();
        chk_wr("t6_restart", 0, 1'b0, 20'd0, 32'h900, 1'b0);

        chk("we_excl", 64'(both_we), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
